wb_trace_buffer: RTL

Write-back trace capture block for the minimal SOPC. It samples every architectural register write leaving the CPU write-back stage, tags it with a cycle timestamp, and queues it in a FIFO. A simulation checker or debug port drains the FIFO through a valid/ready handshake. The testbench only drives clock and reset into the SOPC; this block is the observation path back out of it.

---
 rtl/wb_trace_buffer.sv | 118 +++++++++++
 1 files changed

// File: rtl/wb_trace_buffer.sv
// Write-back trace FIFO: timestamps every captured register write, 1-cycle capture-to-visible latency.
// Consumer drains via trace_valid/trace_ready; a write arriving into a full FIFO with no pop is dropped and counted.
module wb_trace_buffer #(
   parameter int DEPTH    = 16,
   parameter int TS_WIDTH = 16,
   parameter int DROP_R0  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wb_we,
   input  logic [4:0]                 wb_waddr,
   input  logic [31:0]                wb_wdata,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [4:0]                 trace_addr,
   output logic [31:0]                trace_data,
   output logic [TS_WIDTH-1:0]        trace_ts,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic [7:0]                 drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam bit FILTER_R0 = (DROP_R0 != 0);
   localparam logic [TS_WIDTH-1:0] TS_ONE   = 1;
   localparam logic [PW-1:0]       PTR_ONE  = 1;
   localparam logic [CW-1:0]       CNT_ONE  = 1;
   localparam logic [CW-1:0]       CNT_FULL = CW'(DEPTH);

   typedef struct packed {
      logic [4:0]          addr;
      logic [31:0]         data;
      logic [TS_WIDTH-1:0] ts;
   } entry_t;

   entry_t              mem [DEPTH];
   entry_t              head;
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;
   logic [CW-1:0]       count_q;
   logic [TS_WIDTH-1:0] ts_q;
   logic                overflow_q;
   logic [7:0]          drop_q;

   logic capture;
   logic full;
   logic pop;
   logic push;
   logic drop;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign capture = wb_we && !(FILTER_R0 && (wb_waddr == 5'd0));
   assign full    = (count_q == CNT_FULL);
   assign pop     = (count_q != '0) && trace_ready;
   assign push    = capture && (!full || pop);
   assign drop    = capture && full && !pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (clr) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_q <= count_q - CNT_ONE;
         end
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) begin
               drop_q <= drop_q + 8'd1;
            end
         end
      end
   end

   // Storage is left unreset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (push && !clr) begin
         mem[wr_ptr] <= '{addr: wb_waddr, data: wb_wdata, ts: ts_q};
      end
   end

   assign head        = mem[rd_ptr];
   assign trace_valid = (count_q != '0);
   assign trace_addr  = trace_valid ? head.addr : '0;
   assign trace_data  = trace_valid ? head.data : '0;
   assign trace_ts    = trace_valid ? head.ts   : '0;
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign drop_cnt    = drop_q;

endmodule
